// File: rtl/homo_env_decimator.sv
// homo_env_decimator
// Output stage of the homomorphic envelogram chain. Each input sample has a
// programmable DC offset removed (with saturation). The result is then
// decimated by 2^LOG2_DECIM per time-interleaved channel, either by keeping
// the last sample of each window or by a boxcar average. AXI-Stream handshakes
// are used on both sides, behind a single output register.

module homo_env_decimator #(
  parameter int DATA_W     = 32,
  parameter int NCH        = 1,
  parameter int LOG2_DECIM = 3,
  parameter int CH_W       = $clog2(NCH) + 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cfg_mode,
  input  logic [DATA_W-1:0] cfg_offset,
  input  logic [DATA_W-1:0] s_axis_data_tdata,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic [CH_W-1:0]   m_axis_data_tuser,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic              overflow
);

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_AVG  = 1'b1
  } mode_e;

  localparam int ACC_W = DATA_W + LOG2_DECIM;
  // Accumulator bank is sized to a power of two so the channel counter can
  // index it directly; entries at or above NCH are never addressed.
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACC_N = 1 << IDX_W;

  localparam logic [CH_W-1:0]       CH_LAST  = CH_W'(NCH - 1);
  localparam logic [LOG2_DECIM-1:0] PH_LAST  = '1;
  localparam logic [DATA_W-1:0]     SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]     SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [CH_W-1:0]         ch_cnt;
  logic [LOG2_DECIM-1:0]   phase;
  mode_e                   mode_q;
  logic signed [ACC_W-1:0] acc [ACC_N];

  logic                    accept;
  logic                    emit;
  logic [IDX_W-1:0]        ch_idx;
  logic [DATA_W:0]         diff;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [DATA_W-1:0]       y;
  logic signed [ACC_W-1:0] y_ext;

  // The single output register may be refilled in the same cycle it drains.
  assign s_axis_data_tready = aresetn & (~m_axis_data_tvalid | m_axis_data_tready);
  assign accept             = s_axis_data_tvalid & s_axis_data_tready;
  assign emit               = accept & (phase == PH_LAST);
  assign ch_idx             = ch_cnt[IDX_W-1:0];

  // One extra bit so that both directions of overflow can be detected.
  assign diff   = {s_axis_data_tdata[DATA_W-1], s_axis_data_tdata}
                - {cfg_offset[DATA_W-1], cfg_offset};
  assign sat_hi = (diff[DATA_W:DATA_W-1] == 2'b01);
  assign sat_lo = (diff[DATA_W:DATA_W-1] == 2'b10);

  // Clamp the offset-corrected sample to the DATA_W signed range.
  always_comb begin
    // NOTE: assign a default first so that no path through always_comb leaves y unassigned (which would infer a latch).
    y = diff[DATA_W-1:0];
    if (sat_hi) begin
      y = SAT_MAX;
    end else if (sat_lo) begin
      y = SAT_MIN;
    end
  end

  assign y_ext = {{LOG2_DECIM{y[DATA_W-1]}}, y};

  // Channel/phase counters, window mode latch and sticky overflow flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!aresetn) begin
      ch_cnt   <= '0;
      phase    <= '0;
      mode_q   <= MODE_PICK;
      overflow <= 1'b0;
    end else if (accept) begin
      if (phase == '0 && ch_cnt == '0) begin
        mode_q <= mode_e'(cfg_mode);
      end
      if (sat_hi || sat_lo) begin
        overflow <= 1'b1;
      end
      if (ch_cnt == CH_LAST) begin
        ch_cnt <= '0;
        phase  <= phase + 1'b1;
      end else begin
        ch_cnt <= ch_cnt + 1'b1;
      end
    end
  end

  // Per-channel window accumulators.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the accumulator bank is small and is cleared on reset so that a partial window never leaks out.
      for (int i = 0; i < ACC_N; i++) begin
        acc[i] <= '0;
      end
    end else if (accept) begin
      if (phase == '0) begin
        acc[ch_idx] <= y_ext;
      end else if (phase != PH_LAST) begin
        acc[ch_idx] <= acc[ch_idx] + y_ext;
      end
    end
  end

  // Output register: loaded on the last phase, held while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
      m_axis_data_tuser  <= '0;
    end else if (emit) begin
      m_axis_data_tvalid <= 1'b1;
      m_axis_data_tuser  <= ch_cnt;
      if (mode_q == MODE_AVG) begin
        // Arithmetic shift floors; the mean of DECIM in-range samples fits DATA_W.
        m_axis_data_tdata <= DATA_W'((acc[ch_idx] + y_ext) >>> LOG2_DECIM);
      end else begin
        m_axis_data_tdata <= y;
      end
    end else if (m_axis_data_tready) begin
      m_axis_data_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_homo_env_decimator.sv
// Directed testbench for homo_env_decimator. It uses two instances: a single
// channel with decimation by 4, and two channels with decimation by 2.

module tb_homo_env_decimator;

  localparam logic [31:0] OFS = 32'h0400_0000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [31:0] cfg_offset = OFS;

  logic [31:0] a_sdata = '0;
  logic        a_svalid = 1'b0;
  logic        a_sready;
  logic [31:0] a_mdata;
  logic [0:0]  a_muser;
  logic        a_mvalid;
  logic        a_mready = 1'b1;
  logic        a_ovf;

  logic [31:0] b_sdata = '0;
  logic        b_svalid = 1'b0;
  logic        b_sready;
  logic [31:0] b_mdata;
  logic [1:0]  b_muser;
  logic        b_mvalid;
  logic        b_mready = 1'b1;
  logic        b_ovf;

  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  homo_env_decimator #(.DATA_W(32), .NCH(1), .LOG2_DECIM(2)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .cfg_mode(cfg_mode), .cfg_offset(cfg_offset),
    .s_axis_data_tdata(a_sdata), .s_axis_data_tvalid(a_svalid), .s_axis_data_tready(a_sready),
    .m_axis_data_tdata(a_mdata), .m_axis_data_tuser(a_muser), .m_axis_data_tvalid(a_mvalid),
    .m_axis_data_tready(a_mready), .overflow(a_ovf)
  );

  homo_env_decimator #(.DATA_W(32), .NCH(2), .LOG2_DECIM(1)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .cfg_mode(cfg_mode), .cfg_offset(cfg_offset),
    .s_axis_data_tdata(b_sdata), .s_axis_data_tvalid(b_svalid), .s_axis_data_tready(b_sready),
    .m_axis_data_tdata(b_mdata), .m_axis_data_tuser(b_muser), .m_axis_data_tvalid(b_mvalid),
    .m_axis_data_tready(b_mready), .overflow(b_ovf)
  );

  // Present one sample on A and return 1 ns after the accepting edge.
  task automatic send_a(input logic [31:0] d);
    int n;
    n = 0;
    @(negedge aclk);
    a_sdata = d;
    a_svalid = 1'b1;
    while (!a_sready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL send_a_timeout got ready=%0b want 1", a_sready);
    end else begin
      @(posedge aclk); #1;
    end
    a_svalid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d);
    int n;
    n = 0;
    @(negedge aclk);
    b_sdata = d;
    b_svalid = 1'b1;
    while (!b_sready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL send_b_timeout got ready=%0b want 1", b_sready);
    end else begin
      @(posedge aclk); #1;
    end
    b_svalid = 1'b0;
  endtask

  task automatic expect_a(input string name, input logic [31:0] d, input logic [0:0] u);
    total++;
    if ({a_mvalid, a_muser, a_mdata} !== {1'b1, u, d}) begin
      bad++;
      $display("FAIL %s got v=%0b u=%0d d=%h want v=1 u=%0d d=%h", name, a_mvalid, a_muser, a_mdata, u, d);
    end
  endtask

  task automatic expect_a_idle(input string name);
    total++;
    if (a_mvalid !== 1'b0) begin
      bad++;
      $display("FAIL %s got valid=%0b want 0", name, a_mvalid);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge aclk);
    total++;
    if ({a_mvalid, a_mdata, a_muser, a_ovf, a_sready} !== 36'h0) begin
      bad++;
      $display("FAIL reset_a got v=%0b d=%h u=%0d ovf=%0b rdy=%0b want all 0", a_mvalid, a_mdata, a_muser, a_ovf, a_sready);
    end
    total++;
    if ({b_mvalid, b_mdata, b_muser, b_ovf, b_sready} !== 37'h0) begin
      bad++;
      $display("FAIL reset_b got v=%0b d=%h u=%0d ovf=%0b rdy=%0b want all 0", b_mvalid, b_mdata, b_muser, b_ovf, b_sready);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (a_sready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got %0b want 1", a_sready);
    end
  endtask

  task automatic test_pick;
    cfg_mode = 1'b0;
    send_a(32'h0400_0010);
    send_a(32'h0400_0020);
    send_a(32'h0400_0030);
    expect_a_idle("pick_no_early_out");
    send_a(32'h0400_0040);
    expect_a("pick_out", 32'h0000_0040, 1'b0);
    @(posedge aclk); #1;
    expect_a_idle("pick_valid_clears");
  endtask

  task automatic test_avg;
    cfg_mode = 1'b1;
    send_a(32'h0400_0010);
    send_a(32'h0400_0020);
    send_a(32'h0400_0030);
    send_a(32'h0400_0040);
    expect_a("avg_out", 32'h0000_0028, 1'b0);
    send_a(OFS - 32'd1);
    send_a(OFS - 32'd2);
    send_a(OFS - 32'd2);
    send_a(OFS - 32'd2);
    expect_a("avg_floor_neg", 32'hFFFF_FFFE, 1'b0);
  endtask

  task automatic test_channels;
    cfg_mode = 1'b1;
    send_b(OFS + 32'h10);
    send_b(OFS + 32'h100);
    send_b(OFS + 32'h30);
    total++;
    if ({b_mvalid, b_muser, b_mdata} !== {1'b1, 2'd0, 32'h20}) begin
      bad++;
      $display("FAIL ch0_avg got v=%0b u=%0d d=%h want v=1 u=0 d=00000020", b_mvalid, b_muser, b_mdata);
    end
    send_b(OFS + 32'h300);
    total++;
    if ({b_mvalid, b_muser, b_mdata} !== {1'b1, 2'd1, 32'h200}) begin
      bad++;
      $display("FAIL ch1_avg got v=%0b u=%0d d=%h want v=1 u=1 d=00000200", b_mvalid, b_muser, b_mdata);
    end
    @(posedge aclk); #1;
    total++;
    if (b_mvalid !== 1'b0) begin
      bad++;
      $display("FAIL ch_valid_clears got %0b want 0", b_mvalid);
    end
  endtask

  task automatic test_backpressure;
    int stall_bad;
    cfg_mode = 1'b0;
    a_mready = 1'b0;
    send_a(OFS + 32'h11);
    send_a(OFS + 32'h22);
    send_a(OFS + 32'h33);
    send_a(OFS + 32'h44);
    expect_a("stall_out", 32'h44, 1'b0);
    stall_bad = 0;
    a_sdata = OFS + 32'h99;
    a_svalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if ({a_sready, a_mvalid, a_muser, a_mdata} !== {1'b0, 1'b1, 1'b0, 32'h44}) stall_bad++;
    end
    a_svalid = 1'b0;
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL stall_hold got %0d bad cycles want 0 (rdy=%0b d=%h)", stall_bad, a_sready, a_mdata);
    end
    a_mready = 1'b1;
    @(posedge aclk); #1;
    expect_a_idle("stall_release");
  endtask

  task automatic test_random_stall;
    logic [31:0] exp_q[$];
    int got;
    int cyc;
    cfg_mode = 1'b1;
    got = 0;
    cyc = 0;
    fork
      begin
        for (int w = 0; w < 250; w++) begin
          longint sum;
          sum = 0;
          for (int k = 0; k < 4; k++) begin
            int yi;
            yi = int'($urandom_range(0, 2000)) - 1000;
            sum += longint'(yi);
            repeat ($urandom_range(0, 1)) @(negedge aclk);
            send_a(OFS + 32'(yi));
          end
          exp_q.push_back(32'(sum >>> 2));
        end
      end
      begin
        while (got < 250 && cyc < 20000) begin
          @(negedge aclk);
          cyc++;
          if (a_mvalid && a_mready) begin
            logic [31:0] e;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL rand_extra_out got d=%h want none", a_mdata);
            end else begin
              e = exp_q.pop_front();
              if (a_mdata !== e) begin
                bad++;
                $display("FAIL rand_out #%0d got d=%h want %h", got, a_mdata, e);
              end
            end
            got++;
          end
          @(posedge aclk); #2;
          a_mready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    a_mready = 1'b1;
    total++;
    if (got != 250 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_count got %0d outputs (%0d pending) want 250 (0)", got, exp_q.size());
    end
  endtask

  task automatic test_saturation;
    cfg_mode = 1'b0;
    @(negedge aclk);
    total++;
    if (a_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_initial got %0b want 0", a_ovf);
    end
    send_a(OFS + 32'h100);
    send_a(OFS + 32'h200);
    send_a(OFS + 32'h300);
    send_a(32'h8000_0000);
    expect_a("sat_out", 32'h8000_0000, 1'b0);
    total++;
    if (a_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set got %0b want 1", a_ovf);
    end
    send_a(OFS + 32'h1);
    send_a(OFS + 32'h2);
    send_a(OFS + 32'h3);
    send_a(OFS + 32'h4);
    expect_a("post_sat_out", 32'h4, 1'b0);
    total++;
    if (a_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got %0b want 1", a_ovf);
    end
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    total++;
    if (a_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_cleared got %0b want 0", a_ovf);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_reset_mid_window;
    int rst_bad;
    cfg_mode = 1'b1;
    send_a(OFS + 32'h10);
    send_a(OFS + 32'h20);
    @(negedge aclk);
    aresetn = 1'b0;
    rst_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      if (a_mvalid !== 1'b0 || a_sready !== 1'b0) rst_bad++;
    end
    total++;
    if (rst_bad != 0) begin
      bad++;
      $display("FAIL mid_reset_outputs got %0d bad cycles want 0", rst_bad);
    end
    aresetn = 1'b1;
    send_a(OFS + 32'h100);
    send_a(OFS + 32'h200);
    send_a(OFS + 32'h300);
    expect_a_idle("clean_window_no_early_out");
    send_a(OFS + 32'h400);
    expect_a("clean_window_avg", 32'h280, 1'b0);
    cfg_mode = 1'b1;
    send_a(OFS + 32'h8);
    cfg_mode = 1'b0;
    send_a(OFS + 32'h10);
    send_a(OFS + 32'h18);
    send_a(OFS + 32'h20);
    expect_a("toggle_keeps_avg", 32'h14, 1'b0);
    send_a(OFS + 32'h1);
    cfg_mode = 1'b1;
    send_a(OFS + 32'h2);
    send_a(OFS + 32'h3);
    send_a(OFS + 32'h4);
    expect_a("next_window_pick", 32'h4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pick();
    test_avg();
    test_channels();
    test_backpressure();
    test_random_stall();
    test_saturation();
    test_reset_mid_window();
    repeat (2) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
